// File: rtl/collide_pkg.sv
// Shared types and constants for the sphere-collision datapath.
// Imported by the distance sequencer and its operand register.
package collide_pkg;

    localparam int FP_W = 32;

    // Quiet NaN returned in place of a distance when the unit never answers.
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } dist_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dist_operand_reg.sv
// Six-word operand holding register feeding the free-running distance unit.
// Loads on an accepted request and otherwise keeps its contents untouched.
module dist_operand_reg
    import collide_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            load,
    input  logic [FP_W-1:0] a1,
    input  logic [FP_W-1:0] a2,
    input  logic [FP_W-1:0] a3,
    input  logic [FP_W-1:0] b1,
    input  logic [FP_W-1:0] b2,
    input  logic [FP_W-1:0] b3,
    output logic [FP_W-1:0] q_a1,
    output logic [FP_W-1:0] q_a2,
    output logic [FP_W-1:0] q_a3,
    output logic [FP_W-1:0] q_b1,
    output logic [FP_W-1:0] q_b2,
    output logic [FP_W-1:0] q_b3
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_a1 <= '0;
            q_a2 <= '0;
            q_a3 <= '0;
            q_b1 <= '0;
            q_b2 <= '0;
            q_b3 <= '0;
        end else if (load) begin
            q_a1 <= a1;
            q_a2 <= a2;
            q_a3 <= a3;
            q_b1 <= b1;
            q_b2 <= b2;
            q_b3 <= b3;
        end
    end

endmodule

// File: rtl/dist_req_sequencer.sv
// Initiator-side sequencer for dCalcPointsDistance3: accepts an operand set,
// pulses the unit's reset, waits for its result level and hands it downstream.
module dist_req_sequencer
    import collide_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            CLK,
    input  logic            RST_N,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a1,
    input  logic [FP_W-1:0] in_a2,
    input  logic [FP_W-1:0] in_a3,
    input  logic [FP_W-1:0] in_b1,
    input  logic [FP_W-1:0] in_b2,
    input  logic [FP_W-1:0] in_b3,

    output logic [FP_W-1:0] dist_a1,
    output logic [FP_W-1:0] dist_a2,
    output logic [FP_W-1:0] dist_a3,
    output logic [FP_W-1:0] dist_b1,
    output logic [FP_W-1:0] dist_b2,
    output logic [FP_W-1:0] dist_b3,
    output logic            dist_rst,
    input  logic            dist_out_rdy,
    input  logic [FP_W-1:0] dist_res,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_res,
    output logic            out_timeout
);

    localparam int CNT_W = $clog2(max_int(CLEAR_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dist_seq_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // in_ready is a registered copy of (state == IDLE), so accept never
    // depends combinationally on the downstream handshake.
    assign accept = in_valid & in_ready;

    dist_operand_reg u_operands (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (accept),
        .a1    (in_a1),
        .a2    (in_a2),
        .a3    (in_a3),
        .b1    (in_b1),
        .b2    (in_b2),
        .b3    (in_b3),
        .q_a1  (dist_a1),
        .q_a2  (dist_a2),
        .q_a3  (dist_a3),
        .q_b1  (dist_b1),
        .q_b2  (dist_b2),
        .q_b3  (dist_b3)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b1;
            dist_rst    <= 1'b1;
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                    end
                end

                CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        state    <= RUN;
                        cnt      <= '0;
                        dist_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A result arriving on the last allowed cycle still beats the timeout.
                RUN: begin
                    if (dist_out_rdy) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_res     <= dist_res;
                        out_timeout <= 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_res     <= FP_QNAN;
                        out_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        dist_rst  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
